// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller: state encoding, BCD digit width,
// 7-segment decode and a BCD legality helper used at elaboration.
package dice_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Segment order seg[0]=a .. seg[6]=g, active-high; non-decimal codes stay dark.
  function automatic logic [6:0] seg7(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic bcd_legal(input logic [4*BCD_W-1:0] v, input int unsigned nd);
    bcd_legal = 1'b1;
    for (int unsigned k = 0; k < nd; k++) begin
      if (v[k*BCD_W +: BCD_W] > BCD_W'(9)) bcd_legal = 1'b0;
    end
  endfunction

endpackage

// File: rtl/bcd_down_wrap.sv
// Multi-digit BCD down counter: counts toward 1 and wraps back to load_val.
module bcd_down_wrap
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_DIGITS*BCD_W-1:0]   load_val,
  input  logic                          dec,
  output logic [NUM_DIGITS*BCD_W-1:0]   value
);

  localparam int unsigned VW = NUM_DIGITS * BCD_W;

  logic [VW-1:0] dec_val_c;
  logic          is_one_c;

  // Digit-serial borrow chain: a zero digit becomes 9 and passes the borrow up.
  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    dec_val_c = value;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (borrow) begin
        if (value[k*BCD_W +: BCD_W] == '0) begin
          dec_val_c[k*BCD_W +: BCD_W] = BCD_W'(9);
        end else begin
          dec_val_c[k*BCD_W +: BCD_W] = value[k*BCD_W +: BCD_W] - BCD_W'(1);
          borrow = 1'b0;
        end
      end
    end
  end

  assign is_one_c = (value == VW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= VW'(1);
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= is_one_c ? load_val : dec_val_c;
    end
  end

endmodule

// File: rtl/dice_roller_core.sv
// Dice engine: button-selected die spins while held, freezes on release and
// is shown on a multiplexed 7-segment display until the tick timeout expires.
module dice_roller_core
  import dice_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 7,
  parameter int unsigned NUM_DIGITS    = 3,
  parameter logic [NUM_BTN*NUM_DIGITS*BCD_W-1:0] SIDES_BCD =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004},
  parameter int unsigned TIMEOUT_TICKS = 255,
  parameter int unsigned TIMEOUT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        scan_tick,
  input  logic [NUM_BTN-1:0]          btn,
  output logic [6:0]                  seg,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic [NUM_DIGITS*BCD_W-1:0] result_bcd,
  output logic                        result_vld,
  output logic                        busy
);

  localparam int unsigned VW    = NUM_DIGITS * BCD_W;
  localparam int unsigned SEL_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Reject non-BCD entries and one-sided dice while elaborating.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_sides_chk
    localparam logic [VW-1:0] S = SIDES_BCD[g*VW +: VW];
    if (!bcd_legal(16'(S), NUM_DIGITS) || (S == VW'(1))) begin : g_bad
      $error("dice_roller_core: illegal SIDES_BCD entry");
    end
  end

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      sel_l, sel_nxt;
  logic [TIMEOUT_W-1:0]  tmo, tmo_nxt;
  logic [IDX_W-1:0]      scan_idx, scan_nxt;
  logic                  vld_nxt, busy_nxt;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] dig_en_nxt;

  logic [SEL_W-1:0]      sel_c;
  logic                  press_c, held_c, load_c, dec_c, blank_c, show_c;
  logic [VW-1:0]         sel_sides_c, lat_sides_c, load_val_c, value;
  logic [BCD_W-1:0]      digit_c;

  // Lowest enabled pressed button wins; also look up the latched button.
  always_comb begin
    sel_c       = '0;
    press_c     = 1'b0;
    sel_sides_c = '0;
    held_c      = 1'b0;
    lat_sides_c = '0;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (btn[i] && (SIDES_BCD[i*VW +: VW] != '0)) begin
        press_c     = 1'b1;
        sel_c       = SEL_W'(i);
        sel_sides_c = SIDES_BCD[i*VW +: VW];
      end
      if (sel_l == SEL_W'(i)) begin
        held_c      = btn[i];
        lat_sides_c = SIDES_BCD[i*VW +: VW];
      end
    end
  end

  assign load_val_c = (state == ROLL) ? lat_sides_c : sel_sides_c;

  // Next-state logic; a press out of SHOW takes priority over timeout expiry.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_l;
    tmo_nxt   = tmo;
    vld_nxt   = 1'b0;
    load_c    = 1'b0;
    dec_c     = 1'b0;
    case (state)
      IDLE: begin
        if (press_c) begin
          state_nxt = ROLL;
          load_c    = 1'b1;
          sel_nxt   = sel_c;
        end
      end
      ROLL: begin
        if (held_c) begin
          dec_c = 1'b1;
        end else begin
          state_nxt = SHOW;
          vld_nxt   = 1'b1;
          tmo_nxt   = TIMEOUT_W'(TIMEOUT_TICKS);
        end
      end
      SHOW: begin
        if (press_c) begin
          state_nxt = ROLL;
          load_c    = 1'b1;
          sel_nxt   = sel_c;
        end else if (tick) begin
          if (tmo <= TIMEOUT_W'(1)) state_nxt = IDLE;
          if (tmo != '0) tmo_nxt = tmo - TIMEOUT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == ROLL);
  end

  bcd_down_wrap #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_value (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (load_val_c),
    .dec      (dec_c),
    .value    (value)
  );

  assign result_bcd = value;

  // Digit pick and leading-zero blanking for the current scan position.
  always_comb begin
    logic lz;
    digit_c = '0;
    blank_c = 1'b0;
    lz      = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) digit_c = value[k*BCD_W +: BCD_W];
    end
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz = lz && (value[k*BCD_W +: BCD_W] == '0);
      if ((scan_idx == IDX_W'(k)) && lz) blank_c = 1'b1;
    end
    show_c     = (state == SHOW) && !blank_c;
    seg_nxt    = show_c ? seg7(digit_c) : 7'h00;
    dig_en_nxt = show_c ? (NUM_DIGITS'(1) << scan_idx) : '0;
    scan_nxt   = scan_idx;
    if (scan_tick) begin
      scan_nxt = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_l      <= '0;
      tmo        <= '0;
      scan_idx   <= '0;
      result_vld <= 1'b0;
      busy       <= 1'b0;
      seg        <= '0;
      dig_en     <= '0;
    end else begin
      state      <= state_nxt;
      sel_l      <= sel_nxt;
      tmo        <= tmo_nxt;
      scan_idx   <= scan_nxt;
      result_vld <= vld_nxt;
      busy       <= busy_nxt;
      seg        <= seg_nxt;
      dig_en     <= dig_en_nxt;
    end
  end

endmodule

// File: tb/tb_dice_roller_core.sv
// Self-checking bench for dice_roller_core: vector table for a d6 roll,
// scoreboard for frozen results, hand sequences for timeout and reset cases.
module tb_dice_roller_core;

  localparam int unsigned NB = 7;
  localparam int unsigned ND = 3;
  localparam int unsigned VW = 4 * ND;
  localparam logic [NB*VW-1:0] SIDES  =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004};
  localparam logic [NB*VW-1:0] SIDES2 =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h000};

  logic          clk = 1'b0;
  logic          rst_n, tick, scan_tick;
  logic [NB-1:0] btn, btn2;
  logic [6:0]    seg, seg2;
  logic [ND-1:0] dig_en, dig_en2;
  logic [VW-1:0] result_bcd, result_bcd2;
  logic          result_vld, result_vld2, busy, busy2;

  int n_chk  = 0;
  int n_fail = 0;
  int scan_m = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] sb_e;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct packed {
    logic [NB-1:0] btn;
    logic          push;
    logic [VW-1:0] val;
    logic          busy;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  dice_roller_core #(
    .NUM_BTN(NB), .NUM_DIGITS(ND), .SIDES_BCD(SIDES),
    .TIMEOUT_TICKS(3), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .scan_tick(scan_tick), .btn(btn),
    .seg(seg), .dig_en(dig_en), .result_bcd(result_bcd),
    .result_vld(result_vld), .busy(busy)
  );

  dice_roller_core #(
    .NUM_BTN(NB), .NUM_DIGITS(ND), .SIDES_BCD(SIDES2),
    .TIMEOUT_TICKS(3), .TIMEOUT_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .scan_tick(scan_tick), .btn(btn2),
    .seg(seg2), .dig_en(dig_en2), .result_bcd(result_bcd2),
    .result_vld(result_vld2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] to_bcd(input int v);
    to_bcd = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_pulse();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    scan_m = (scan_m + 1) % int'(ND);
    step();
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  // Expected display for the model's scan position, with leading-zero blanking.
  task automatic disp_check(input string name, input logic [VW-1:0] val);
    logic [3:0]    d;
    logic          blank;
    logic [ND-1:0] e_en;
    logic [6:0]    e_seg;
    d     = val[scan_m*4 +: 4];
    blank = 1'b0;
    if (scan_m == 2) blank = (val[11:8] == 4'h0);
    if (scan_m == 1) blank = (val[11:4] == 8'h00);
    e_en  = blank ? '0 : (ND'(1) << scan_m);
    e_seg = blank ? 7'h00 : seg_tab[d];
    check({name, "_dig_en"}, 32'(dig_en), 32'(e_en));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

  // Hold a button for n cycles checking the spin, then release and expect the freeze.
  task automatic hold(input logic [NB-1:0] mask, input int sides, input int n);
    btn = mask;
    for (int k = 0; k < n; k++) begin
      step();
      check("spin_value", 32'(result_bcd), 32'(to_bcd(sides - (k % sides))));
      check("spin_busy", 32'(busy), 32'd1);
    end
    btn = '0;
    exp_q.push_back(to_bcd(sides - ((n - 1) % sides)));
    step();
    check("release_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard: every result_vld pulse must match the next queued result.
  always @(posedge clk) begin
    #1;
    if (result_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_vld", 32'(result_vld), 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("result_bcd_on_vld", 32'(result_bcd), 32'(sb_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 9; i++) vecs[i] = '{btn: 7'h02, push: 1'b0, val: to_bcd(6 - (i % 6)), busy: 1'b1};
    vecs[9]  = '{btn: 7'h00, push: 1'b1, val: 12'h004, busy: 1'b0};
    vecs[10] = '{btn: 7'h00, push: 1'b0, val: 12'h004, busy: 1'b0};

    // Reset
    rst_n = 1'b0; tick = 1'b0; scan_tick = 1'b0; btn = '0; btn2 = '0;
    step(2);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dig_en", 32'(dig_en), 32'd0);
    check("rst_result", 32'(result_bcd), 32'h001);
    check("rst_vld", 32'(result_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // d6 roll from the vector table
    for (int i = 0; i < 11; i++) begin
      btn = vecs[i].btn;
      if (vecs[i].push) exp_q.push_back(vecs[i].val);
      step();
      check($sformatf("vec%0d_value", i), 32'(result_bcd), 32'(vecs[i].val));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end
    disp_check("d6_show", 12'h004);
    for (int s = 0; s < 3; s++) begin
      scan_pulse();
      disp_check($sformatf("d6_scan%0d", s), 12'h004);
    end

    // d100 with 100 -> 099 borrow
    hold(7'h40, 100, 94);
    check("d100_result", 32'(result_bcd), 32'h007);
    for (int s = 0; s < 3; s++) begin
      scan_pulse();
      disp_check($sformatf("d100_scan%0d", s), 12'h007);
    end

    // Timeout expiry after three ticks
    for (int t = 0; t < 2; t++) begin
      tick_pulse();
      check("tmo_busy", 32'(busy), 32'd0);
      disp_check($sformatf("tmo_still_shown%0d", t), 12'h007);
    end
    tick_pulse();
    check("tmo_expired_dig_en", 32'(dig_en), 32'd0);
    check("tmo_expired_seg", 32'(seg), 32'd0);

    // Press on the expiring tick wins
    hold(7'h02, 6, 2);
    tick_pulse();
    tick_pulse();
    tick = 1'b1;
    btn  = 7'h02;
    step();
    check("press_wins_busy", 32'(busy), 32'd1);
    check("press_wins_value", 32'(result_bcd), 32'h006);
    tick = 1'b0;
    btn  = '0;
    exp_q.push_back(12'h006);
    step();
    check("press_wins_release_busy", 32'(busy), 32'd0);

    // Two buttons: lowest (d4) wins, other ignored until release
    tick_pulse(); tick_pulse(); tick_pulse();
    check("idle_before_d4", 32'(busy), 32'd0);
    btn = 7'h09;
    for (int k = 0; k < 6; k++) begin
      step();
      check("d4_spin", 32'(result_bcd), 32'(to_bcd(4 - (k % 4))));
    end
    btn = 7'h08;
    exp_q.push_back(12'h003);
    step();
    check("d4_show_busy", 32'(busy), 32'd0);
    step();
    check("d10_reroll_busy", 32'(busy), 32'd1);
    check("d10_reroll_value", 32'(result_bcd), 32'h010);
    btn = '0;
    exp_q.push_back(12'h010);
    step();
    check("d10_release_busy", 32'(busy), 32'd0);

    // Reset in the middle of a roll
    btn = 7'h40;
    for (int k = 0; k < 3; k++) begin
      step();
      check("pre_rst_spin", 32'(result_bcd), 32'(to_bcd(100 - k)));
    end
    rst_n = 1'b0;
    btn   = '0;
    step(2);
    scan_m = 0;
    check("midrst_result", 32'(result_bcd), 32'h001);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vld", 32'(result_vld), 32'd0);
    check("midrst_dig_en", 32'(dig_en), 32'd0);
    check("midrst_seg", 32'(seg), 32'd0);
    rst_n = 1'b1;
    step(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_result", 32'(result_bcd), 32'h001);
    check("post_rst_dig_en", 32'(dig_en), 32'd0);

    // Disabled entry stays idle; enabled neighbour still rolls
    btn2 = 7'h01;
    for (int k = 0; k < 4; k++) begin
      step();
      check("dis_busy", 32'(busy2), 32'd0);
      check("dis_vld", 32'(result_vld2), 32'd0);
    end
    check("dis_result", 32'(result_bcd2), 32'h001);
    check("dis_dig_en", 32'(dig_en2), 32'd0);
    check("dis_seg", 32'(seg2), 32'd0);
    btn2 = 7'h02;
    step();
    check("en_busy", 32'(busy2), 32'd1);
    check("en_value", 32'(result_bcd2), 32'h006);
    btn2 = '0;
    step(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
